// File: rtl/qspi_mem_arbiter.sv
// Arbitrates instruction-fetch and data load/store requests onto one QSPI master.
// Optional watchdog abort on a hung master is enabled by defining QSPI_ARB_WATCHDOG_EN.
module qspi_mem_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [23:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [23:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        m_start,
  output logic        m_stop,
  output logic        m_write_enable,
  output logic        m_is_instr,
  output logic [23:0] m_addr,
  output logic [5:0]  m_data_len,
  output logic [31:0] m_data_in,
  input  logic [31:0] m_data_out,
  input  logic        m_done,
  output logic        err
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StStop, StRecover} state_e;

  state_e      state_q;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic [31:0] fmt_rdata;
  logic        timeout, fire;

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

`ifdef QSPI_ARB_WATCHDOG_EN
  logic [15:0] wd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= 16'd0;
    end else if (state_q == StIssue) begin
      wd_q <= 16'd0;
    end else if (state_q == StWait) begin
      wd_q <= wd_q + 16'd1;
    end
  end

  // A completion arriving on the timeout cycle wins over the abort.
  assign timeout = (state_q == StWait) && !m_done && (wd_q == TIMEOUT_CYCLES);
`else
  logic [15:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  assign err  = timeout;
  assign fire = (state_q == StWait) && (m_done || timeout);

  // Read data is steered by the latched transfer length; instructions latch length 0.
  always_comb begin
    fmt_rdata = bswap(m_data_out);
    if (timeout) begin
      fmt_rdata = 32'h0;
    end else begin
      case (m_data_len)
        6'd8:    fmt_rdata = {24'h0, m_data_out[7:0]};
        6'd16:   fmt_rdata = {16'h0, m_data_out[7:0], m_data_out[15:8]};
        default: fmt_rdata = bswap(m_data_out);
      endcase
    end
  end

  assign i_ready = fire && m_is_instr;
  assign d_ready = fire && !m_is_instr;
  assign i_rdata = i_ready ? fmt_rdata : i_rdata_q;
  assign d_rdata = (d_ready && (!m_write_enable || timeout)) ? fmt_rdata : d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      m_start        <= 1'b0;
      m_stop         <= 1'b0;
      m_write_enable <= 1'b0;
      m_is_instr     <= 1'b0;
      m_addr         <= 24'h0;
      m_data_len     <= 6'd0;
      m_data_in      <= 32'h0;
      i_rdata_q      <= 32'h0;
      d_rdata_q      <= 32'h0;
    end else begin
      i_rdata_q <= i_rdata;
      d_rdata_q <= d_rdata;
      case (state_q)
        StIdle: begin
          if (d_req) begin
            state_q        <= StIssue;
            m_start        <= 1'b1;
            m_write_enable <= d_we;
            m_is_instr     <= 1'b0;
            m_addr         <= d_addr;
            case (d_size)
              2'd0: begin
                m_data_len <= 6'd8;
                m_data_in  <= d_we ? {d_wdata[7:0], 24'h0} : 32'h0;
              end
              2'd1: begin
                m_data_len <= 6'd16;
                m_data_in  <= d_we ? {d_wdata[7:0], d_wdata[15:8], 16'h0} : 32'h0;
              end
              default: begin
                m_data_len <= 6'd32;
                m_data_in  <= d_we ? bswap(d_wdata) : 32'h0;
              end
            endcase
          end else if (i_req) begin
            state_q        <= StIssue;
            m_start        <= 1'b1;
            m_write_enable <= 1'b0;
            m_is_instr     <= 1'b1;
            m_addr         <= i_addr;
            m_data_len     <= 6'd0;
            m_data_in      <= 32'h0;
          end
        end
        StIssue: begin
          m_start <= 1'b0;
          state_q <= StWait;
        end
        StWait: begin
          if (fire) begin
            if (m_is_instr || timeout) begin
              state_q <= StStop;
              m_stop  <= 1'b1;
            end else begin
              state_q <= StRecover;
            end
          end
        end
        StStop: begin
          m_stop  <= 1'b0;
          state_q <= StRecover;
        end
        StRecover: state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Directed bench for qspi_mem_arbiter: table of transactions plus hand-written corner sequences.
// Watchdog sequence runs only when QSPI_ARB_WATCHDOG_EN is defined.
module tb_qspi_mem_arbiter;

  logic        clk, rst_n;
  logic        i_req, i_ready;
  logic [23:0] i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_ready;
  logic [1:0]  d_size;
  logic [23:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        m_start, m_stop, m_write_enable, m_is_instr, m_done, err;
  logic [23:0] m_addr;
  logic [5:0]  m_data_len;
  logic [31:0] m_data_in, m_data_out;

  int checks = 0;
  int errors = 0;

  qspi_mem_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_start(m_start), .m_stop(m_stop), .m_write_enable(m_write_enable),
    .m_is_instr(m_is_instr), .m_addr(m_addr), .m_data_len(m_data_len),
    .m_data_in(m_data_in), .m_data_out(m_data_out), .m_done(m_done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_i;
    logic        we;
    logic [1:0]  size;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdout;
    logic [5:0]  len;
    logic [31:0] din;
    logic [31:0] rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_start) begin
        found = 1'b1;
        break;
      end
    end
    chk("start_seen", 32'(found), 32'd1);
  endtask

  task automatic run_txn(input vec_t v);
    bit found;
    @(posedge clk); #1;
    if (v.is_i) begin
      i_req = 1'b1; i_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
    end
    wait_start(found);
    if (!found) begin
      i_req = 1'b0; d_req = 1'b0;
      return;
    end
    chk("m_addr", 32'(m_addr), 32'(v.addr));
    chk("m_data_len", 32'(m_data_len), 32'(v.len));
    chk("m_is_instr", 32'(m_is_instr), 32'(v.is_i));
    chk("m_write_enable", 32'(m_write_enable), 32'(v.we));
    if (v.we) chk("m_data_in", m_data_in, v.din);
    @(posedge clk); #1;
    m_done = 1'b1; m_data_out = v.mdout;
    @(negedge clk);
    chk("i_ready", 32'(i_ready), 32'(v.is_i));
    chk("d_ready", 32'(d_ready), 32'(!v.is_i));
    chk("err_quiet", 32'(err), 32'd0);
    chk("rdata", v.is_i ? i_rdata : d_rdata, v.rdata);
    chk("m_start_low", 32'(m_start), 32'd0);
    @(posedge clk); #1;
    m_done = 1'b0; i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("m_stop_after_done", 32'(m_stop), 32'(v.is_i));
    chk("ready_one_cycle", 32'(i_ready | d_ready), 32'd0);
    @(negedge clk);
    chk("m_stop_one_cycle", 32'(m_stop), 32'd0);
    chk("rdata_held", v.is_i ? i_rdata : d_rdata, v.rdata);
  endtask

  vec_t vecs[8];

  initial begin
    bit found;
    rst_n = 1'b0; i_req = 1'b0; i_addr = 24'h0; d_req = 1'b0; d_we = 1'b0;
    d_size = 2'd0; d_addr = 24'h0; d_wdata = 32'h0; m_data_out = 32'h0; m_done = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 2'd0, 24'h0, 32'h0, 32'h0, 6'd0, 32'h0, 32'h0};
    vecs[0] = '{1'b0, 1'b0, 2'd2, 24'h000100, 32'h0, 32'h11223344, 6'd32, 32'h0, 32'h44332211};
    vecs[1] = '{1'b0, 1'b1, 2'd0, 24'h000204, 32'hDEADBEEF, 32'h0, 6'd8, 32'hEF000000,
                32'h44332211};
    vecs[2] = '{1'b0, 1'b0, 2'd1, 24'h000302, 32'h0, 32'hAABBCCDD, 6'd16, 32'h0, 32'h0000DDCC};
    vecs[3] = '{1'b0, 1'b0, 2'd0, 24'h000403, 32'h0, 32'h12345678, 6'd8, 32'h0, 32'h00000078};
    vecs[4] = '{1'b0, 1'b1, 2'd1, 24'h000506, 32'h12345678, 32'h0, 6'd16, 32'h78560000,
                32'h00000078};
    vecs[5] = '{1'b0, 1'b1, 2'd3, 24'h000608, 32'h01020304, 32'h0, 6'd32, 32'h04030201,
                32'h00000078};
    vecs[6] = '{1'b0, 1'b0, 2'd3, 24'hABCDEF, 32'h0, 32'hA1B2C3D4, 6'd32, 32'h0, 32'hD4C3B2A1};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 24'h000040, 32'h0, 32'h01450000, 6'd0, 32'h0, 32'h00004501};

    #12;
    chk("reset_outputs_zero", 32'(|{m_start, m_stop, m_write_enable, m_is_instr, m_addr,
        m_data_len, m_data_in, i_ready, d_ready, i_rdata, d_rdata, err}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Simultaneous requests: data first, fetch only after RECOVER.
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 24'h000080;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 24'h000900;
    wait_start(found);
    chk("sim_first_is_data", 32'(m_is_instr), 32'd0);
    @(posedge clk); #1;
    m_done = 1'b1; m_data_out = 32'hCAFEF00D;
    @(negedge clk);
    chk("sim_d_ready", 32'(d_ready), 32'd1);
    chk("sim_i_ready_low", 32'(i_ready), 32'd0);
    chk("sim_d_rdata", d_rdata, 32'h0DF0FECA);
    @(posedge clk); #1;
    m_done = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("sim_recover_no_start", 32'(m_start | m_stop), 32'd0);
    wait_start(found);
    chk("sim_second_is_instr", 32'(m_is_instr), 32'd1);
    chk("sim_second_addr", 32'(m_addr), 32'h000080);
    @(posedge clk); #1;
    m_done = 1'b1; m_data_out = 32'h13000000;
    @(negedge clk);
    chk("sim2_i_ready", 32'(i_ready), 32'd1);
    chk("sim2_d_ready_low", 32'(d_ready), 32'd0);
    chk("sim2_i_rdata", i_rdata, 32'h00000013);
    @(posedge clk); #1;
    m_done = 1'b0; i_req = 1'b0;
    repeat (2) @(negedge clk);

    // m_done outside WAIT must be ignored.
    @(posedge clk); #1;
    m_done = 1'b1; m_data_out = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray_done_ignored", 32'(i_ready | d_ready), 32'd0);
    chk("stray_done_rdata", d_rdata, 32'h0DF0FECA);
    @(posedge clk); #1;
    m_done = 1'b0;

    // Reset while in WAIT abandons the transaction.
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_addr = 24'h123456; d_wdata = 32'h55667788;
    wait_start(found);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs_zero", 32'(|{m_start, m_stop, m_write_enable, m_is_instr, m_addr,
        m_data_len, m_data_in, i_ready, d_ready, i_rdata, d_rdata, err}), 32'd0);
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    m_done = 1'b1;
    @(negedge clk);
    chk("midreset_no_ready", 32'(i_ready | d_ready), 32'd0);
    m_done = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_txn(vecs[0]);

`ifdef QSPI_ARB_WATCHDOG_EN
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 24'h000700;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (err) begin
        found = 1'b1;
        break;
      end
    end
    chk("wd_err_seen", 32'(found), 32'd1);
    chk("wd_d_ready", 32'(d_ready), 32'(found));
    chk("wd_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    chk("wd_m_stop", 32'(m_stop), 32'd1);
    chk("wd_err_one_cycle", 32'(err), 32'd0);
    run_txn(vecs[3]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_mem_arbiter.md
QSPI_MEM_ARBITER -- requirements
Module: qspi_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd8192, the watchdog limit in clk cycles (used only with the macro).
REQ-002 SHALL have port clk input 1: system clock.
REQ-003 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-004 SHALL have ports i_req input 1, i_addr input 24, i_ready output 1, i_rdata output 32: instruction-fetch port.
REQ-005 SHALL have ports d_req input 1, d_we input 1, d_size input 2 (0=byte, 1=half, 2=word), d_addr input 24, d_wdata input 32, d_ready output 1, d_rdata output 32: data load/store port.
REQ-006 SHALL have ports m_start output 1, m_stop output 1, m_write_enable output 1, m_is_instr output 1, m_addr output 24, m_data_len output 6, m_data_in output 32, m_data_out input 32, m_done input 1: QSPI master side.
REQ-007 SHALL have port err output 1: one-cycle pulse on watchdog abort.

Function
REQ-008 SHALL implement states IDLE, ISSUE, WAIT, STOP and RECOVER.
REQ-009 IDLE, with d_req high: SHALL latch the data request and go to ISSUE.
REQ-010 IDLE, with only i_req high: SHALL latch the instruction request and go to ISSUE.
REQ-011 When i_req and d_req are both high in the same cycle, d_req SHALL win; i_req stays pending.
REQ-012 ISSUE: m_start SHALL be high for exactly one cycle, then the state SHALL move to WAIT.
REQ-013 m_write_enable, m_is_instr, m_addr, m_data_len and m_data_in SHALL be registered at latch time and held stable from ISSUE until the block returns to IDLE.
REQ-014 m_data_len SHALL be 8, 16 or 32 for d_size 0, 1 or 2; d_size 3 SHALL be treated as 2. Instruction transactions SHALL drive 0.
REQ-015 m_data_in SHALL be left-aligned with the first byte in [31:24]. Byte store: {wdata[7:0],24'h0}. Half store: {wdata[7:0],wdata[15:8],16'h0}. Word store: byteswap(wdata).
REQ-016 Data read result: d_rdata SHALL be byteswap(m_data_out) for word, {16'h0,m_data_out[7:0],m_data_out[15:8]} for half, and {24'h0,m_data_out[7:0]} for byte.
REQ-017 Instruction result: i_rdata SHALL be byteswap(m_data_out). A compressed fetch therefore returns {16'h0, halfword}.
REQ-018 Data transaction, on m_done in WAIT: SHALL pulse d_ready and update d_rdata (loads only) in the same cycle as m_done, then go to RECOVER.
REQ-019 Instruction transaction, on m_done in WAIT: SHALL pulse i_ready with i_rdata in the same cycle as m_done, then go to STOP.
REQ-020 STOP: m_stop SHALL be high for one cycle, then the state SHALL move to RECOVER.
REQ-021 RECOVER: SHALL last one cycle with no m_start, then go to IDLE. Back-to-back requests therefore start no sooner than 4 cycles apart, plus master latency.
REQ-022 i_ready and d_ready SHALL each be one-cycle pulses, never high together.
REQ-023 A requester SHALL hold its req and operands until its ready pulse; req is sampled only in IDLE.
REQ-024 i_rdata and d_rdata SHALL hold their last value between transactions.
REQ-025 m_done seen outside WAIT SHALL be ignored.

Reset
REQ-026 On rst_n low, the state SHALL be IDLE.
REQ-027 On rst_n low, all outputs SHALL be 0: m_start, m_stop, m_write_enable, m_is_instr, m_addr, m_data_len, m_data_in, i_ready, d_ready, i_rdata, d_rdata, err.
REQ-028 On rst_n low, the watchdog counter SHALL be 0.
REQ-029 Reset mid-transaction SHALL abandon it with no ready pulse; m_stop is not required during reset.

Configuration
REQ-030 Macro QSPI_ARB_WATCHDOG_EN defined: a 16-bit counter SHALL clear in ISSUE and increment in WAIT.
REQ-031 With the macro, when the counter reaches TIMEOUT_CYCLES: err SHALL pulse, the requester's ready SHALL pulse with rdata 32'h0, and the block SHALL go to STOP regardless of transaction type.
REQ-032 Macro not defined: there SHALL be no counter, err SHALL be tied to 0, and WAIT SHALL wait indefinitely.

Verification
REQ-033 Word load: d_req=1, d_size=2, d_addr=24'h000100, master returns m_data_out=32'h11223344 -> m_data_len=32, m_is_instr=0, d_rdata=32'h44332211 with one d_ready pulse, no m_stop.
REQ-034 Byte store: d_we=1, d_size=0, d_wdata=32'hDEADBEEF -> m_write_enable=1, m_data_len=8, m_data_in=32'hEF000000, d_ready pulse after m_done.
REQ-035 Compressed fetch: i_req=1, i_addr=24'h000040, m_data_out=32'h01450000 -> i_rdata=32'h00004501, then m_stop pulses exactly one cycle later.
REQ-036 Simultaneous i_req and d_req in IDLE: data served first; the instruction m_start is issued only after RECOVER, and the ready pulses never overlap.
REQ-037 Watchdog (macro defined, TIMEOUT_CYCLES=16): m_done never asserted -> err, d_ready and m_stop asserted, d_rdata=0, return to IDLE.
REQ-038 rst_n low while in WAIT: all outputs 0 immediately, state IDLE, a later request completes normally.
